// File: rtl/execute_cycle_pkg.sv
// Shared constants for the RV32I execute stage: ALU opcodes, forward selects
// and the operand forwarding mux used for both ALU inputs.
package execute_cycle_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The unused select 11 falls back to the register-file operand.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] mem_val
  );
    case (sel)
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return rf_val;
    endcase
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational 32-bit ALU for the execute stage; carry and overflow are not
// produced, and unassigned opcodes yield zero.
module alu
  import execute_cycle_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, BEQ resolution and the EX/MEM
// pipeline register that feeds the memory stage.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 ResultSrcE,
  input  logic                 ALUSrcE,
  input  logic                 BranchE,
  input  logic [2:0]           ALUControlE,
  input  logic [XLEN-1:0]      RD1_E,
  input  logic [XLEN-1:0]      RD2_E,
  input  logic [XLEN-1:0]      Imm_Ext_E,
  input  logic [XLEN-1:0]      PCE,
  input  logic [XLEN-1:0]      PCPlus4E,
  input  logic [REG_IDX_W-1:0] RD_E,
  input  logic [1:0]           ForwardA_E,
  input  logic [1:0]           ForwardB_E,
  input  logic [XLEN-1:0]      ResultW,
  output logic                 PCSrcE,
  output logic [XLEN-1:0]      PCTargetE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 ResultSrcM,
  output logic [REG_IDX_W-1:0] RD_M,
  output logic [XLEN-1:0]      ALUResultM,
  output logic [XLEN-1:0]      WriteDataM,
  output logic [XLEN-1:0]      PCPlus4M
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // The MEM-stage forward source is this stage's own registered ALU result.
  always_comb begin
    src_a = fwd_mux(ForwardA_E, RD1_E, ResultW, ALUResultM);
    fwd_b = fwd_mux(ForwardB_E, RD2_E, ResultW, ALUResultM);
    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  alu u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  assign PCSrcE    = BranchE & alu_zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // Store data takes the forwarded B, never the immediate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: reset, ALU ops, forwarding, store data,
// branch resolution and asynchronous mid-cycle reset.
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int n_checks = 0;
  int n_errors = 0;

  execute_cycle dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .ResultSrcE (ResultSrcE),
    .ALUSrcE    (ALUSrcE),
    .BranchE    (BranchE),
    .ALUControlE(ALUControlE),
    .RD1_E      (RD1_E),
    .RD2_E      (RD2_E),
    .Imm_Ext_E  (Imm_Ext_E),
    .PCE        (PCE),
    .PCPlus4E   (PCPlus4E),
    .RD_E       (RD_E),
    .ForwardA_E (ForwardA_E),
    .ForwardB_E (ForwardB_E),
    .ResultW    (ResultW),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RD_M       (RD_M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; results sampled there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic alusrc, input logic [31:0] imm,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] resw);
    ALUControlE = op;
    RD1_E       = a;
    RD2_E       = b;
    ALUSrcE     = alusrc;
    Imm_Ext_E   = imm;
    ForwardA_E  = fa;
    ForwardB_E  = fb;
    ResultW     = resw;
  endtask

  task automatic set_ctrl(input logic rw, input logic mw, input logic rs, input logic br,
                          input logic [4:0] rd);
    RegWriteE  = rw;
    MemWriteE  = mw;
    ResultSrcE = rs;
    BranchE    = br;
    RD_E       = rd;
  endtask

  initial begin
    rst = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 5'd17);
    drive(3'b000, 32'h11, 32'h22, 1'b0, 32'h33, 2'b00, 2'b00, 32'h44);
    PCE      = 32'h200;
    PCPlus4E = 32'h204;

    // reset held with live inputs and clock
    repeat (3) step();
    check("rst_regwrite",  RegWriteM,  32'd0);
    check("rst_memwrite",  MemWriteM,  32'd0);
    check("rst_resultsrc", ResultSrcM, 32'd0);
    check("rst_rd",        RD_M,       32'd0);
    check("rst_aluresult", ALUResultM, 32'd0);
    check("rst_writedata", WriteDataM, 32'd0);
    check("rst_pcplus4",   PCPlus4M,   32'd0);

    // release, first instruction ADD 5 + imm 7
    rst = 1'b1;
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
    drive(3'b000, 32'd5, 32'd0, 1'b1, 32'd7, 2'b00, 2'b00, 32'd0);
    step();
    check("add_imm",       ALUResultM, 32'd12);
    check("pass_regwrite", RegWriteM,  32'd1);
    check("pass_resultsrc",ResultSrcM, 32'd1);
    check("pass_rd",       RD_M,       32'd9);
    check("pass_pcplus4",  PCPlus4M,   32'h204);

    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(3'b001, 32'd3, 32'd5, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("sub_neg", ALUResultM, 32'hFFFFFFFE);
    check("bubble_regwrite", RegWriteM, 32'd0);

    drive(3'b101, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("slt_m1_1", ALUResultM, 32'd1);

    drive(3'b101, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("slt_1_m1", ALUResultM, 32'd0);

    drive(3'b000, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("add_wrap", ALUResultM, 32'd0);

    drive(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("and", ALUResultM, 32'h00F0_1200);

    drive(3'b011, 32'hF000_0001, 32'h0000_0F10, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("or", ALUResultM, 32'hF000_0F11);

    drive(3'b111, 32'd7, 32'd3, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("op111_zero", ALUResultM, 32'd0);

    drive(3'b100, 32'd7, 32'd3, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("op100_zero", ALUResultM, 32'd0);

    // forwarding chain
    drive(3'b000, 32'd2, 32'd3, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0);
    step();
    check("fwd_base", ALUResultM, 32'd5);

    drive(3'b000, 32'd100, 32'd1, 1'b0, 32'd0, 2'b10, 2'b00, 32'd0);
    step();
    check("fwd_a_mem", ALUResultM, 32'd6);

    drive(3'b000, 32'd100, 32'd1, 1'b0, 32'd0, 2'b10, 2'b01, 32'd9);
    step();
    check("fwd_b_wb", ALUResultM, 32'd15);
    check("fwd_b_wdata", WriteDataM, 32'd9);

    drive(3'b000, 32'd20, 32'd3, 1'b0, 32'd0, 2'b11, 2'b11, 32'd9);
    step();
    check("fwd_sel11", ALUResultM, 32'd23);

    drive(3'b000, 32'd20, 32'd3, 1'b0, 32'd0, 2'b01, 2'b01, 32'd4);
    step();
    check("fwd_both_wb", ALUResultM, 32'd8);

    drive(3'b000, 32'd20, 32'd3, 1'b0, 32'd0, 2'b10, 2'b10, 32'd4);
    step();
    check("fwd_both_mem", ALUResultM, 32'd16);

    // store: address from immediate, data forwarded from writeback
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(3'b000, 32'h1000, 32'd0, 1'b1, 32'h10, 2'b00, 2'b01, 32'hDEADBEEF);
    step();
    check("store_data", WriteDataM, 32'hDEADBEEF);
    check("store_addr", ALUResultM, 32'h1010);
    check("store_memwrite", MemWriteM, 32'd1);

    // async reset between edges drops the in-flight store
    #2;
    rst = 1'b0;
    #1;
    check("async_memwrite", MemWriteM, 32'd0);
    check("async_aluresult", ALUResultM, 32'd0);
    check("async_writedata", WriteDataM, 32'd0);
    step();
    check("held_memwrite", MemWriteM, 32'd0);
    rst = 1'b1;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

    // branch resolution is combinational
    PCE = 32'h100;
    drive(3'b001, 32'd4, 32'd4, 1'b0, 32'hFFFFFFF8, 2'b00, 2'b00, 32'd0);
    #1;
    check("beq_taken", PCSrcE, 32'd1);
    check("beq_target", PCTargetE, 32'h000000F8);

    drive(3'b001, 32'd4, 32'd5, 1'b0, 32'hFFFFFFF8, 2'b00, 2'b00, 32'd0);
    #1;
    check("beq_not_taken", PCSrcE, 32'd0);

    BranchE = 1'b0;
    drive(3'b001, 32'd4, 32'd4, 1'b0, 32'h20, 2'b00, 2'b00, 32'd0);
    #1;
    check("no_branch", PCSrcE, 32'd0);
    check("target_fwd", PCTargetE, 32'h120);

    step();
    check("post_reset_sub", ALUResultM, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RV32I pipeline. It sits directly downstream of `decode_cycle` and consumes that block's ID/EX register outputs. It resolves operand forwarding, performs the ALU operation and computes the branch target and taken decision. Its results are registered into the EX/MEM pipeline register that feeds the memory stage.

## Interface
- No parameters (data width is fixed at 32, register index width at 5).
- Reset is asynchronous and active-low.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE`  in  1 each  control bits from ID/EX.
- `ALUControlE`  in  3  ALU opcode from ID/EX.
- `RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E`  in  32 each  operands, immediate and PC values from ID/EX.
- `RD_E`  in  5  destination register index.
- `ForwardA_E, ForwardB_E`  in  2 each  forwarding selects from the hazard unit.
- `ResultW`  in  32  writeback-stage result (forwarding source).
- `PCSrcE`  out  1  branch taken (combinational).
- `PCTargetE`  out  32  branch target (combinational).
- `RegWriteM, MemWriteM, ResultSrcM`  out  1 each  registered control.
- `RD_M`  out  5  registered destination index.
- `ALUResultM, WriteDataM, PCPlus4M`  out  32 each  registered datapath.

## Operation
- Operand A select by `ForwardA_E`:
  - 00 → `RD1_E`
  - 01 → `ResultW`
  - 10 → `ALUResultM` (this block's own registered output)
  - 11 → reserved, behaves as 00.
- Forwarded B uses the same rule on `ForwardB_E`/`RD2_E`.
- Operand B select: `ALUSrcE`=1 → `Imm_Ext_E`; 0 → forwarded B.
- ALU opcodes:
  - 000 ADD: A+B mod 2^32.
  - 001 SUB: A−B mod 2^32.
  - 010 AND.
  - 011 OR.
  - 101 SLT: 1 if signed A<B, else 0.
  - Any other code: result 0.
- Carry and overflow are discarded.
- Zero = (ALU result == 0).
- `PCSrcE` = `BranchE` & Zero (BEQ only).
- `PCTargetE` = `PCE` + `Imm_Ext_E`, mod 2^32.
- `WriteDataM` captures the forwarded B, never the immediate, so stores following a dependent instruction write the correct data.
- EX/MEM register captures each cycle: `RegWriteE`, `MemWriteE`, `ResultSrcE`, `RD_E`, ALU result, forwarded B, `PCPlus4E`.

## Timing
- Single-cycle stage: values presented on E inputs in cycle n appear on M outputs after the rising edge ending cycle n (latency 1).
- `PCSrcE`/`PCTargetE` are purely combinational from the current E inputs, valid within cycle n.
- Reset:
  - While `rst`=0, every registered output is 0 (`RegWriteM`, `MemWriteM`, `ResultSrcM`=0, `RD_M`=5'h00, all 32-bit M outputs 32'h00000000), independent of `clk`.
  - Asserting `rst` mid-operation clears the EX/MEM register immediately and drops any in-flight instruction.
  - Release takes effect at the next rising edge.
- Back-to-back dependency: the ALU result of instruction i is forwardable via `ForwardX_E`=10 to instruction i+1 in the next cycle, and via `ResultW` (=01) two cycles later.
- Both forward selects may point at the same source in the same cycle; this is legal.
- There is no stall or flush input. Bubbles arrive as all-zero control from the upstream register.

## Structure
- Shared package/header holds:
  - ALU opcode localparams: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`.
  - Forward-select localparams: `FWD_RF`=00, `FWD_WB`=01, `FWD_MEM`=10.
- One sub-module, `alu`: combinational, with inputs A, B, ALUControl and outputs Result, Zero.
- The forwarding muxes, branch adder and EX/MEM register live in `execute_cycle`.

## Test plan
- Reset: hold `rst`=0 with non-zero E inputs and toggling `clk` → all M outputs 0. Release with ADD, `RD1_E`=5, `Imm_Ext_E`=7, `ALUSrcE`=1 → next edge `ALUResultM`=12.
- ALU coverage:
  - SUB 3−5 → 32'hFFFFFFFE.
  - SLT −1 vs 1 → 1.
  - SLT 1 vs −1 → 0.
  - ADD 32'hFFFFFFFF+1 → 0.
  - Opcode 111 → 0.
- Forwarding:
  - Cycle 1: ADD 2+3 (`ALUResultM`=5).
  - Cycle 2: `ForwardA_E`=10, `RD1_E`=100, `RD2_E`=1, ADD → `ALUResultM`=6.
  - Repeat with `ForwardB_E`=01, `ResultW`=9 → B=9.
  - Select 11 → register-file value is used.
- Store data: `ALUSrcE`=1, `ForwardB_E`=01, `ResultW`=32'hDEADBEEF, `RD2_E`=0 → `WriteDataM`=32'hDEADBEEF.
- Branch:
  - `BranchE`=1, SUB 4−4, `PCE`=32'h100, `Imm_Ext_E`=32'hFFFFFFF8 → `PCSrcE`=1, `PCTargetE`=32'hF8.
  - Operands 4,5 → `PCSrcE`=0.
  - `BranchE`=0 with Zero=1 → `PCSrcE`=0.
- Async reset mid-stream: assert `rst` between clock edges after a MemWrite instruction → `MemWriteM` drops to 0 immediately without waiting for a clock edge.
